clock2_core: RTL

- Parametrised successor to the free-running hh:mm:ss timekeeper.
- Adds a configurable 1 Hz prescaler, a button-driven time-set state machine, a 12/24-hour display mode and a per-digit blink mask for the field being set.
- Drives six BCD digits directly, so no downstream bin2bcd is needed; per-digit hex7seg decoders follow.
- Sits between the board inputs (CLOCK_50, debounced KEYs, switch) and the HEX display decoders.

---
 rtl/clock2_core_if.sv | 28 ++
 rtl/clock2_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock2_core_if.sv
// Board-side bundle for clock2_core: debounced key/switch levels in, BCD digits and status out.
interface clock2_core_if;
    logic       mode_i;
    logic       inc_i;
    logic       fmt24_i;
    logic [3:0] hrs_msb_o;
    logic [3:0] hrs_lsb_o;
    logic [3:0] mins_msb_o;
    logic [3:0] mins_lsb_o;
    logic [3:0] secs_msb_o;
    logic [3:0] secs_lsb_o;
    logic       pm_o;
    logic [5:0] blank_o;
    logic       sec_tick_o;
    logic       alarm_o;

    modport slave (
        input  mode_i, inc_i, fmt24_i,
        output hrs_msb_o, hrs_lsb_o, mins_msb_o, mins_lsb_o, secs_msb_o, secs_lsb_o,
        output pm_o, blank_o, sec_tick_o, alarm_o
    );

    modport master (
        output mode_i, inc_i, fmt24_i,
        input  hrs_msb_o, hrs_lsb_o, mins_msb_o, mins_lsb_o, secs_msb_o, secs_lsb_o,
        input  pm_o, blank_o, sec_tick_o, alarm_o
    );
endinterface

// File: rtl/clock2_core.sv
// hh:mm:ss timekeeper with 1 Hz prescaler, button time-set FSM, 12/24-hour BCD display and blink mask.
// Optional alarm register and alarm edit states are enabled by defining CLOCK2_ALARM_EN.
module clock2_core #(
    parameter int CLK_TC   = 49999999,
    parameter int BLINK_TC = 12499999,
    parameter int CNT_W    = 26
) (
    input  logic          clk_i,
    input  logic          rst_i,
    clock2_core_if.slave  bus
);

`ifdef CLOCK2_ALARM_EN
    typedef enum logic [2:0] {RUN, SET_HRS, SET_MINS, SET_SECS, SET_AL_HRS, SET_AL_MINS} state_t;
`else
    typedef enum logic [2:0] {RUN, SET_HRS, SET_MINS, SET_SECS} state_t;
`endif

    localparam logic [CNT_W-1:0] CLK_TC_C   = CNT_W'(CLK_TC);
    localparam logic [CNT_W-1:0] BLINK_TC_C = CNT_W'(BLINK_TC);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   blinkCnt_q, blinkCnt_d;
    logic               blinkPhase_q, blinkPhase_d;
    logic               modePrev_q, incPrev_q;
    logic [4:0]         hrs_q, hrs_d;
    logic [5:0]         mins_q, mins_d;
    logic [5:0]         secs_q, secs_d;
    logic [4:0]         alHrs_q, alHrs_d;
    logic [5:0]         alMins_q, alMins_d;
    logic               alarm_q;

    logic [3:0]         hrsMsb_q, hrsLsb_q, minsMsb_q, minsLsb_q, secsMsb_q, secsLsb_q;
    logic               pm_q;
    logic [5:0]         blank_q;

    logic               modeEdge, incEdge, tick;
    logic [4:0]         showHrs, hrs12;
    logic [5:0]         showMins, showSecs;
    logic [7:0]         hrsBcd, minsBcd, secsBcd;
    logic               pmNext;
    logic [5:0]         blankNext;

    function automatic logic [7:0] toBcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 6'd10);
        units = 4'(v - 6'(tens) * 6'd10);
        return {tens, units};
    endfunction

    always_comb begin
        modeEdge     = bus.mode_i & ~modePrev_q;
        incEdge      = bus.inc_i & ~incPrev_q;
        tick         = (state_q == RUN) && (presc_q == CLK_TC_C);
        state_d      = state_q;
        hrs_d        = hrs_q;
        mins_d       = mins_q;
        secs_d       = secs_q;
        alHrs_d      = alHrs_q;
        alMins_d     = alMins_q;
        blinkCnt_d   = blinkCnt_q + 1'b1;
        blinkPhase_d = blinkPhase_q;

        if (tick) begin
            if (secs_q == 6'd59) begin
                secs_d = 6'd0;
                if (mins_q == 6'd59) begin
                    mins_d = 6'd0;
                    hrs_d  = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
                end else begin
                    mins_d = mins_q + 6'd1;
                end
            end else begin
                secs_d = secs_q + 6'd1;
            end
        end

        // Field edits come before the mode advance so a simultaneous inc hits the current field
        if (incEdge) begin
            case (state_q)
                SET_HRS:     hrs_d    = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
                SET_MINS:    mins_d   = (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
                SET_SECS:    secs_d   = 6'd0;
`ifdef CLOCK2_ALARM_EN
                SET_AL_HRS:  alHrs_d  = (alHrs_q == 5'd23) ? 5'd0 : alHrs_q + 5'd1;
                SET_AL_MINS: alMins_d = (alMins_q == 6'd59) ? 6'd0 : alMins_q + 6'd1;
`endif
                default: ;
            endcase
        end

        if (modeEdge) begin
            case (state_q)
                RUN:         state_d = SET_HRS;
                SET_HRS:     state_d = SET_MINS;
                SET_MINS:    state_d = SET_SECS;
`ifdef CLOCK2_ALARM_EN
                SET_SECS:    state_d = SET_AL_HRS;
                SET_AL_HRS:  state_d = SET_AL_MINS;
`endif
                default:     state_d = RUN;
            endcase
        end

        presc_d = ((state_q == RUN) && (state_d == RUN)) ? (tick ? '0 : presc_q + 1'b1) : '0;

        if (blinkCnt_q == BLINK_TC_C) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            presc_q      <= '0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
            modePrev_q   <= 1'b0;
            incPrev_q    <= 1'b0;
            hrs_q        <= 5'd0;
            mins_q       <= 6'd0;
            secs_q       <= 6'd0;
            alHrs_q      <= 5'd6;
            alMins_q     <= 6'd0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
            modePrev_q   <= bus.mode_i;
            incPrev_q    <= bus.inc_i;
            hrs_q        <= hrs_d;
            mins_q       <= mins_d;
            secs_q       <= secs_d;
            alHrs_q      <= alHrs_d;
            alMins_q     <= alMins_d;
        end
    end

    always_comb begin
        showHrs  = hrs_q;
        showMins = mins_q;
        showSecs = secs_q;
`ifdef CLOCK2_ALARM_EN
        if (state_q == SET_AL_HRS || state_q == SET_AL_MINS) begin
            showHrs  = alHrs_q;
            showMins = alMins_q;
            showSecs = 6'd0;
        end
`endif
        if (bus.fmt24_i)            hrs12 = showHrs;
        else if (showHrs == 5'd0)   hrs12 = 5'd12;
        else if (showHrs > 5'd12)   hrs12 = showHrs - 5'd12;
        else                        hrs12 = showHrs;
        pmNext  = ~bus.fmt24_i && (showHrs >= 5'd12);
        hrsBcd  = toBcd({1'b0, hrs12});
        minsBcd = toBcd(showMins);
        secsBcd = toBcd(showSecs);

        // Leading-zero suppression in 12-hour mode, plus blink on the field under edit
        blankNext    = 6'b0;
        blankNext[5] = ~bus.fmt24_i && (hrsBcd[7:4] == 4'd0);
        case (state_q)
            SET_HRS:     blankNext[5:4] = blankNext[5:4] | {2{blinkPhase_q}};
            SET_MINS:    blankNext[3:2] = {2{blinkPhase_q}};
            SET_SECS:    blankNext[1:0] = {2{blinkPhase_q}};
`ifdef CLOCK2_ALARM_EN
            SET_AL_HRS:  blankNext[5:4] = blankNext[5:4] | {2{blinkPhase_q}};
            SET_AL_MINS: blankNext[3:2] = {2{blinkPhase_q}};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hrsMsb_q  <= 4'd0;
            hrsLsb_q  <= 4'd0;
            minsMsb_q <= 4'd0;
            minsLsb_q <= 4'd0;
            secsMsb_q <= 4'd0;
            secsLsb_q <= 4'd0;
            pm_q      <= 1'b0;
            blank_q   <= 6'b0;
            alarm_q   <= 1'b0;
        end else begin
            hrsMsb_q  <= hrsBcd[7:4];
            hrsLsb_q  <= hrsBcd[3:0];
            minsMsb_q <= minsBcd[7:4];
            minsLsb_q <= minsBcd[3:0];
            secsMsb_q <= secsBcd[7:4];
            secsLsb_q <= secsBcd[3:0];
            pm_q      <= pmNext;
            blank_q   <= blankNext;
`ifdef CLOCK2_ALARM_EN
            alarm_q   <= (state_q == RUN) && (hrs_q == alHrs_q) && (mins_q == alMins_q);
`else
            alarm_q   <= 1'b0;
`endif
        end
    end

    assign bus.hrs_msb_o  = hrsMsb_q;
    assign bus.hrs_lsb_o  = hrsLsb_q;
    assign bus.mins_msb_o = minsMsb_q;
    assign bus.mins_lsb_o = minsLsb_q;
    assign bus.secs_msb_o = secsMsb_q;
    assign bus.secs_lsb_o = secsLsb_q;
    assign bus.pm_o       = pm_q;
    assign bus.blank_o    = blank_q;
    assign bus.sec_tick_o = tick;
    assign bus.alarm_o    = alarm_q;

endmodule
